// File: rtl/vpu_valu_stream.sv
`default_nettype none
// ============================================================================
// Module   : vpu_valu_stream
// Purpose  : Multi-lane streaming vector ALU, one command then LANES element
//            pairs per beat; registered, tail-masked results.
// Revision : 1.0  initial release
// ============================================================================
module vpu_valu_stream #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int VL_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_op,
    input  logic [VL_W-1:0]         cmd_vl,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_lane_en,
    output logic                    out_last,
    output logic                    busy
);

    localparam int c_SH_W = $clog2(DATA_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [VL_W-1:0]         r_remaining;
    logic [VL_W-1:0]         w_remaining_next;
    logic [3:0]              r_op;
    logic                    w_cmd_fire;
    logic                    w_in_fire;
    logic                    w_last;
    logic [LANES-1:0]        w_lane_en;
    logic [LANES*DATA_W-1:0] w_result;

    logic                    r_out_valid;
    logic [LANES*DATA_W-1:0] r_out_data;
    logic [LANES-1:0]        r_out_lane_en;
    logic                    r_out_last;

    function automatic logic [DATA_W-1:0] alu(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [c_SH_W-1:0] sh;
        logic              lt_s;
        logic              lt_u;
        sh   = b[c_SH_W-1:0];
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        case (op)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = a << sh;
            4'd6:    alu = a >> sh;
            4'd7:    alu = $signed(a) >>> sh;
            4'd8:    alu = {{(DATA_W-1){1'b0}}, lt_s};
            4'd9:    alu = {{(DATA_W-1){1'b0}}, lt_u};
            4'd10:   alu = lt_s ? a : b;
            4'd11:   alu = lt_s ? b : a;
            4'd12:   alu = lt_u ? a : b;
            4'd13:   alu = lt_u ? b : a;
            default: alu = '1;
        endcase
    endfunction

    // Ready signals depend only on state and the output register, never on a valid.
    assign cmd_ready  = (r_state == ST_IDLE);
    assign in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_in_fire  = in_valid && in_ready;

    assign w_last           = (32'(r_remaining) <= LANES);
    assign w_remaining_next = w_last ? '0 : r_remaining - VL_W'(LANES);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_lane_en[i] = (32'(r_remaining) > i);
            assign w_result[i*DATA_W +: DATA_W] =
                w_lane_en[i] ? alu(r_op, in_a[i*DATA_W +: DATA_W], in_b[i*DATA_W +: DATA_W])
                             : '0;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd_fire && (cmd_vl != '0)) w_state_next = ST_RUN;
            ST_RUN:  if (w_in_fire && w_last)           w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_op        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cmd_fire) begin
                r_op        <= cmd_op;
                r_remaining <= cmd_vl;
            end else if (w_in_fire) begin
                r_remaining <= w_remaining_next;
            end
        end
    end

    // A newly loaded beat takes priority over draining the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_lane_en <= '0;
            r_out_last    <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_result;
            r_out_lane_en <= w_lane_en;
            r_out_last    <= w_last;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_lane_en = r_out_lane_en;
    assign out_last    = r_out_last;
    assign busy        = (r_state == ST_RUN) || r_out_valid;

endmodule
`default_nettype wire
